// File: rtl/params_pkg.sv
// Shared widths and the execute-stage record used by the multi-cycle MUL path.
package params_pkg;

   localparam int REGISTER_WIDTH = 5;
   localparam int XLEN           = 32;
   localparam int EX_STAGES      = 5;

   // One pipeline slot: liveness, destination register and the stage's data word.
   typedef struct packed {
      logic                      valid;
      logic [REGISTER_WIDTH-1:0] rd;
      logic [XLEN-1:0]           data;
   } ex_stage_t;

endpackage

// File: rtl/mul_lo_partial.sv
// Combinational partial products for the low half of A*B. The high*high term
// is never formed because it only lands above bit DATA_WIDTH-1.
module mul_lo_partial #(
   parameter int DATA_WIDTH = 32
) (
   input  logic [DATA_WIDTH-1:0] a_i,
   input  logic [DATA_WIDTH-1:0] b_i,
   output logic [DATA_WIDTH-1:0] ll_o,
   output logic [DATA_WIDTH-1:0] lh_o,
   output logic [DATA_WIDTH-1:0] hl_o
);

   localparam int HW = DATA_WIDTH / 2;

   logic [HW-1:0] al;
   logic [HW-1:0] ah;
   logic [HW-1:0] bl;
   logic [HW-1:0] bh;

   assign {ah, al} = a_i;
   assign {bh, bl} = b_i;

   // Zero-extend each half so every product is exactly DATA_WIDTH bits, unsigned.
   assign ll_o = {{HW{1'b0}}, al} * {{HW{1'b0}}, bl};
   assign lh_o = {{HW{1'b0}}, al} * {{HW{1'b0}}, bh};
   assign hl_o = {{HW{1'b0}}, ah} * {{HW{1'b0}}, bl};

endmodule

// File: rtl/ex_mul_pipeline.sv
// Five-stage MUL execute pipeline: ex1 operands, ex2 partial products,
// ex3 low-half sum, ex4/ex5 carry the result to writeback.
// The stage record carries XLEN-wide data, so DATA_WIDTH must equal XLEN
// and be even.
module ex_mul_pipeline
   import params_pkg::*;
#(
   parameter int DATA_WIDTH = XLEN
) (
   input  logic                      clk_i,
   input  logic                      rsn_i,
   input  logic                      issue_valid_i,
   input  logic [REGISTER_WIDTH-1:0] issue_rd_i,
   input  logic [DATA_WIDTH-1:0]     issue_rs1_data_i,
   input  logic [DATA_WIDTH-1:0]     issue_rs2_data_i,
   input  logic                      stall_i,
   input  logic                      bubble_i,
   output logic                      ex1_valid_o,
   output logic                      ex2_valid_o,
   output logic                      ex3_valid_o,
   output logic                      ex4_valid_o,
   output logic                      ex5_valid_o,
   output logic [REGISTER_WIDTH-1:0] ex1_wr_reg_o,
   output logic [REGISTER_WIDTH-1:0] ex2_wr_reg_o,
   output logic [REGISTER_WIDTH-1:0] ex3_wr_reg_o,
   output logic [REGISTER_WIDTH-1:0] ex4_wr_reg_o,
   output logic [REGISTER_WIDTH-1:0] ex5_wr_reg_o,
   output logic                      wb_is_next_cycle_o,
   output logic                      wb_valid_o,
   output logic [REGISTER_WIDTH-1:0] wb_rd_o,
   output logic [DATA_WIDTH-1:0]     wb_data_o,
   output logic                      busy_o
);

   // stage_q[0] = ex1 (data = operand A), stage_q[1] = ex2 (data = al*bl),
   // stage_q[2..4] = ex3..ex5 (data = low-half product).
   ex_stage_t             stage_q [EX_STAGES];
   logic [DATA_WIDTH-1:0] op_b_q;
   logic [DATA_WIDTH-1:0] pp_lh_q;
   logic [DATA_WIDTH-1:0] pp_hl_q;

   logic [DATA_WIDTH-1:0] pp_ll;
   logic [DATA_WIDTH-1:0] pp_lh;
   logic [DATA_WIDTH-1:0] pp_hl;
   logic [DATA_WIDTH-1:0] sum_lo;
   logic                  load_ex1;

   mul_lo_partial #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_mul_lo_partial (
      .a_i (stage_q[0].data),
      .b_i (op_b_q),
      .ll_o(pp_ll),
      .lh_o(pp_lh),
      .hl_o(pp_hl)
   );

   // Cross terms only contribute their low half once shifted; overflow wraps.
   assign sum_lo   = stage_q[1].data + ((pp_lh_q + pp_hl_q) << (DATA_WIDTH / 2));
   assign load_ex1 = issue_valid_i & ~bubble_i;

   // Stage registers: synchronous clear, freeze on stall, otherwise shift one slot.
   always_ff @(posedge clk_i) begin
      if (!rsn_i) begin
         for (int k = 0; k < EX_STAGES; k++) begin
            stage_q[k] <= '0;
         end
         op_b_q  <= '0;
         pp_lh_q <= '0;
         pp_hl_q <= '0;
      end else if (!stall_i) begin
         // ex1 rd/operands are left stale on a bubble; only valid matters then.
         stage_q[0].valid <= load_ex1;
         if (load_ex1) begin
            stage_q[0].rd   <= issue_rd_i;
            stage_q[0].data <= issue_rs1_data_i;
            op_b_q          <= issue_rs2_data_i;
         end

         stage_q[1].valid <= stage_q[0].valid;
         stage_q[1].rd    <= stage_q[0].rd;
         stage_q[1].data  <= pp_ll;
         pp_lh_q          <= pp_lh;
         pp_hl_q          <= pp_hl;

         stage_q[2].valid <= stage_q[1].valid;
         stage_q[2].rd    <= stage_q[1].rd;
         stage_q[2].data  <= sum_lo;

         stage_q[3] <= stage_q[2];
         stage_q[4] <= stage_q[3];
      end
   end

   assign ex1_valid_o  = stage_q[0].valid;
   assign ex2_valid_o  = stage_q[1].valid;
   assign ex3_valid_o  = stage_q[2].valid;
   assign ex4_valid_o  = stage_q[3].valid;
   assign ex5_valid_o  = stage_q[4].valid;
   assign ex1_wr_reg_o = stage_q[0].rd;
   assign ex2_wr_reg_o = stage_q[1].rd;
   assign ex3_wr_reg_o = stage_q[2].rd;
   assign ex4_wr_reg_o = stage_q[3].rd;
   assign ex5_wr_reg_o = stage_q[4].rd;

   assign busy_o = stage_q[0].valid | stage_q[1].valid | stage_q[2].valid
                 | stage_q[3].valid | stage_q[4].valid;

   // A stalled cycle means writeback was not granted, so the request is masked.
   assign wb_valid_o         = stage_q[4].valid & ~stall_i;
   assign wb_rd_o            = stage_q[4].rd;
   assign wb_data_o          = stage_q[4].data;
   assign wb_is_next_cycle_o = stage_q[3].valid;

endmodule

// File: tb/tb_ex_mul_pipeline.sv
// Self-checking bench for ex_mul_pipeline: directed scenarios plus a random
// run compared against a queue of in-flight instructions tagged with age.
module tb_ex_mul_pipeline;
   import params_pkg::*;

   localparam int DW = 32;
   localparam int RW = REGISTER_WIDTH;

   logic          clk_i = 1'b0;
   logic          rsn_i;
   logic          issue_valid_i;
   logic [RW-1:0] issue_rd_i;
   logic [DW-1:0] issue_rs1_data_i;
   logic [DW-1:0] issue_rs2_data_i;
   logic          stall_i;
   logic          bubble_i;
   logic          ex1_valid_o, ex2_valid_o, ex3_valid_o, ex4_valid_o, ex5_valid_o;
   logic [RW-1:0] ex1_wr_reg_o, ex2_wr_reg_o, ex3_wr_reg_o, ex4_wr_reg_o, ex5_wr_reg_o;
   logic          wb_is_next_cycle_o;
   logic          wb_valid_o;
   logic [RW-1:0] wb_rd_o;
   logic [DW-1:0] wb_data_o;
   logic          busy_o;

   logic [4:0]    dv;
   logic [RW-1:0] dr [5];

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      logic [RW-1:0] rd;
      logic [DW-1:0] res;
      int            age;
   } inst_t;
   inst_t q[$];

   ex_mul_pipeline #(.DATA_WIDTH(DW)) dut (
      .clk_i(clk_i), .rsn_i(rsn_i),
      .issue_valid_i(issue_valid_i), .issue_rd_i(issue_rd_i),
      .issue_rs1_data_i(issue_rs1_data_i), .issue_rs2_data_i(issue_rs2_data_i),
      .stall_i(stall_i), .bubble_i(bubble_i),
      .ex1_valid_o(ex1_valid_o), .ex2_valid_o(ex2_valid_o), .ex3_valid_o(ex3_valid_o),
      .ex4_valid_o(ex4_valid_o), .ex5_valid_o(ex5_valid_o),
      .ex1_wr_reg_o(ex1_wr_reg_o), .ex2_wr_reg_o(ex2_wr_reg_o), .ex3_wr_reg_o(ex3_wr_reg_o),
      .ex4_wr_reg_o(ex4_wr_reg_o), .ex5_wr_reg_o(ex5_wr_reg_o),
      .wb_is_next_cycle_o(wb_is_next_cycle_o), .wb_valid_o(wb_valid_o),
      .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o), .busy_o(busy_o)
   );

   always #5 clk_i = ~clk_i;

   assign dv    = {ex5_valid_o, ex4_valid_o, ex3_valid_o, ex2_valid_o, ex1_valid_o};
   assign dr[0] = ex1_wr_reg_o;
   assign dr[1] = ex2_wr_reg_o;
   assign dr[2] = ex3_wr_reg_o;
   assign dr[3] = ex4_wr_reg_o;
   assign dr[4] = ex5_wr_reg_o;

   function automatic int m_find(int age);
      for (int i = 0; i < q.size(); i++) begin
         if (q[i].age == age) return i;
      end
      return -1;
   endfunction

   task automatic drive(bit v, logic [RW-1:0] rd, logic [DW-1:0] a, logic [DW-1:0] b,
                        bit st, bit bu);
      issue_valid_i    = v;
      issue_rd_i       = rd;
      issue_rs1_data_i = a;
      issue_rs2_data_i = b;
      stall_i          = st;
      bubble_i         = bu;
      #1;
   endtask

   task automatic idle();
      drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
   endtask

   // One clock edge; the reference queue ages every instruction on an unstalled edge.
   task automatic step();
      logic [DW-1:0] p;
      @(posedge clk_i);
      if (!rsn_i) begin
         q.delete();
      end else if (!stall_i) begin
         foreach (q[i]) q[i].age++;
         while (q.size() > 0 && q[0].age > EX_STAGES) void'(q.pop_front());
         if (issue_valid_i && !bubble_i) begin
            p = issue_rs1_data_i * issue_rs2_data_i;
            q.push_back('{rd: issue_rd_i, res: p, age: 1});
         end
      end
      @(negedge clk_i);
   endtask

   task automatic test_reset();
      rsn_i = 1'b0;
      drive(1'b1, 5'd7, $urandom, $urandom, 1'b0, 1'b0);
      step();
      step();
      idle();
      n_cmp++; if (dv !== 5'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=%b", dv, 5'b0); end
      for (int k = 0; k < 5; k++) begin
         n_cmp++; if (dr[k] !== '0) begin n_err++; $display("FAIL reset_wr_reg ex%0d got=%0d exp=0", k + 1, dr[k]); end
      end
      n_cmp++; if (wb_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_wb_valid got=%b exp=0", wb_valid_o); end
      n_cmp++; if (wb_data_o !== '0) begin n_err++; $display("FAIL reset_wb_data got=%h exp=0", wb_data_o); end
      n_cmp++; if (wb_rd_o !== '0) begin n_err++; $display("FAIL reset_wb_rd got=%0d exp=0", wb_rd_o); end
      n_cmp++; if (busy_o !== 1'b0 || wb_is_next_cycle_o !== 1'b0) begin
         n_err++; $display("FAIL reset_busy_next got=%b%b exp=00", busy_o, wb_is_next_cycle_o); end
      rsn_i = 1'b1;
   endtask

   task automatic test_single();
      drive(1'b1, 5'd3, 32'd7, 32'd6, 1'b0, 1'b0);
      step();
      idle();
      for (int c = 1; c <= 5; c++) begin
         n_cmp++; if (dv !== (5'b1 << (c - 1))) begin n_err++; $display("FAIL single_valid cyc=%0d got=%b exp=%b", c, dv, 5'b1 << (c - 1)); end
         n_cmp++; if (dr[c-1] !== 5'd3) begin n_err++; $display("FAIL single_wr_reg cyc=%0d got=%0d exp=3", c, dr[c-1]); end
         n_cmp++; if (wb_is_next_cycle_o !== (c == 4)) begin n_err++; $display("FAIL single_wb_next cyc=%0d got=%b exp=%b", c, wb_is_next_cycle_o, c == 4); end
         n_cmp++; if (wb_valid_o !== (c == 5)) begin n_err++; $display("FAIL single_wb_valid cyc=%0d got=%b exp=%b", c, wb_valid_o, c == 5); end
         if (c == 5) begin
            n_cmp++; if (wb_rd_o !== 5'd3 || wb_data_o !== 32'd42) begin
               n_err++; $display("FAIL single_wb got rd=%0d data=%0d exp rd=3 data=42", wb_rd_o, wb_data_o); end
         end
         step();
      end
      n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL single_drain_busy got=%b exp=0", busy_o); end
   endtask

   task automatic test_wrap();
      logic [DW-1:0] ta [3];
      logic [DW-1:0] tb [3];
      logic [DW-1:0] te [3];
      ta[0] = 32'hFFFF_FFFF; tb[0] = 32'hFFFF_FFFF; te[0] = 32'h0000_0001;
      ta[1] = 32'h8000_0000; tb[1] = 32'h0000_0002; te[1] = 32'h0000_0000;
      ta[2] = 32'h0001_2345; tb[2] = 32'h0001_0000; te[2] = 32'h2345_0000;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 5'(i + 10), ta[i], tb[i], 1'b0, 1'b0);
         step();
         idle();
         repeat (4) step();
         n_cmp++; if (wb_valid_o !== 1'b1 || wb_data_o !== te[i]) begin
            n_err++; $display("FAIL wrap case=%0d got valid=%b data=%h exp valid=1 data=%h", i, wb_valid_o, wb_data_o, te[i]); end
         step();
      end
   endtask

   task automatic test_back_to_back();
      logic [DW-1:0] a [6];
      logic [DW-1:0] b [6];
      logic [DW-1:0] e;
      for (int i = 1; i <= 5; i++) begin
         a[i] = $urandom;
         b[i] = $urandom;
         drive(1'b1, 5'(i), a[i], b[i], 1'b0, 1'b0);
         step();
      end
      idle();
      n_cmp++; if (dv !== 5'b11111 || busy_o !== 1'b1) begin
         n_err++; $display("FAIL b2b_full got valid=%b busy=%b exp valid=11111 busy=1", dv, busy_o); end
      for (int k = 0; k < 5; k++) begin
         n_cmp++; if (dr[k] !== 5'(5 - k)) begin n_err++; $display("FAIL b2b_wr_reg ex%0d got=%0d exp=%0d", k + 1, dr[k], 5 - k); end
      end
      for (int i = 1; i <= 5; i++) begin
         e = a[i] * b[i];
         n_cmp++; if (wb_valid_o !== 1'b1 || wb_rd_o !== 5'(i) || wb_data_o !== e) begin
            n_err++; $display("FAIL b2b_wb n=%0d got v=%b rd=%0d d=%h exp v=1 rd=%0d d=%h", i, wb_valid_o, wb_rd_o, wb_data_o, i, e); end
         step();
      end
   endtask

   task automatic test_stall();
      logic [DW-1:0] a, b, e;
      logic [4:0]    snap;
      a = $urandom;
      b = $urandom;
      e = a * b;
      drive(1'b1, 5'd9, a, b, 1'b0, 1'b0);
      step();
      idle();
      repeat (4) step();
      snap = dv;
      for (int s = 0; s < 3; s++) begin
         drive(1'b1, 5'd12, $urandom, $urandom, 1'b1, 1'b0);
         n_cmp++; if (wb_valid_o !== 1'b0) begin n_err++; $display("FAIL stall_wb_valid s=%0d got=%b exp=0", s, wb_valid_o); end
         n_cmp++; if (dv !== 5'b10000 || dr[4] !== 5'd9 || wb_data_o !== e) begin
            n_err++; $display("FAIL stall_hold s=%0d got valid=%b rd=%0d d=%h exp valid=10000 rd=9 d=%h", s, dv, dr[4], wb_data_o, e); end
         step();
      end
      idle();
      n_cmp++; if (dv !== snap) begin n_err++; $display("FAIL stall_after got valid=%b exp=%b", dv, snap); end
      n_cmp++; if (wb_valid_o !== 1'b1 || wb_rd_o !== 5'd9 || wb_data_o !== e) begin
         n_err++; $display("FAIL stall_release got v=%b rd=%0d d=%h exp v=1 rd=9 d=%h", wb_valid_o, wb_rd_o, wb_data_o, e); end
      step();
   endtask

   task automatic test_bubble();
      drive(1'b1, 5'd2, $urandom, $urandom, 1'b0, 1'b1);
      step();
      n_cmp++; if (ex1_valid_o !== 1'b0) begin n_err++; $display("FAIL bubble_ex1 got=%b exp=0", ex1_valid_o); end
      drive(1'b1, 5'd4, $urandom, $urandom, 1'b0, 1'b0);
      step();
      drive(1'b1, 5'd7, $urandom, $urandom, 1'b1, 1'b1);
      step();
      n_cmp++; if (ex1_valid_o !== 1'b1 || ex1_wr_reg_o !== 5'd4) begin
         n_err++; $display("FAIL stall_bubble_ex1 got v=%b rd=%0d exp v=1 rd=4", ex1_valid_o, ex1_wr_reg_o); end
      idle();
      repeat (6) step();
   endtask

   task automatic test_reset_mid();
      logic [DW-1:0] a, b, e;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 5'(20 + i), $urandom, $urandom, 1'b0, 1'b0);
         step();
      end
      idle();
      rsn_i = 1'b0;
      step();
      rsn_i = 1'b1;
      n_cmp++; if (dv !== 5'b0 || busy_o !== 1'b0) begin
         n_err++; $display("FAIL midreset_clear got valid=%b busy=%b exp 0", dv, busy_o); end
      for (int c = 0; c < 6; c++) begin
         n_cmp++; if (wb_valid_o !== 1'b0) begin n_err++; $display("FAIL midreset_no_wb cyc=%0d got=%b exp=0", c, wb_valid_o); end
         step();
      end
      a = $urandom;
      b = $urandom;
      e = a * b;
      drive(1'b1, 5'd17, a, b, 1'b0, 1'b0);
      step();
      idle();
      repeat (4) step();
      n_cmp++; if (wb_valid_o !== 1'b1 || wb_rd_o !== 5'd17 || wb_data_o !== e) begin
         n_err++; $display("FAIL midreset_reissue got v=%b rd=%0d d=%h exp v=1 rd=17 d=%h", wb_valid_o, wb_rd_o, wb_data_o, e); end
      step();
   endtask

   task automatic test_random();
      int idx;
      for (int c = 0; c < 500; c++) begin
         rsn_i = ($urandom_range(0, 49) != 0);
         drive($urandom_range(0, 3) != 0, 5'($urandom), $urandom, $urandom,
               $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);
         for (int k = 1; k <= 5; k++) begin
            idx = m_find(k);
            n_cmp++; if (dv[k-1] !== (idx >= 0)) begin
               n_err++; $display("FAIL rand_valid c=%0d ex%0d got=%b exp=%b", c, k, dv[k-1], idx >= 0); end
            if (idx >= 0) begin
               n_cmp++; if (dr[k-1] !== q[idx].rd) begin
                  n_err++; $display("FAIL rand_wr_reg c=%0d ex%0d got=%0d exp=%0d", c, k, dr[k-1], q[idx].rd); end
            end
         end
         idx = m_find(5);
         n_cmp++; if (busy_o !== (q.size() > 0) || wb_is_next_cycle_o !== (m_find(4) >= 0)) begin
            n_err++; $display("FAIL rand_busy_next c=%0d got=%b%b exp=%b%b", c, busy_o, wb_is_next_cycle_o, q.size() > 0, m_find(4) >= 0); end
         n_cmp++; if (wb_valid_o !== (idx >= 0 && !stall_i)) begin
            n_err++; $display("FAIL rand_wb_valid c=%0d got=%b exp=%b", c, wb_valid_o, idx >= 0 && !stall_i); end
         if (idx >= 0) begin
            n_cmp++; if (wb_rd_o !== q[idx].rd || wb_data_o !== q[idx].res) begin
               n_err++; $display("FAIL rand_wb c=%0d got rd=%0d d=%h exp rd=%0d d=%h", c, wb_rd_o, wb_data_o, q[idx].rd, q[idx].res); end
         end
         step();
      end
      rsn_i = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rsn_i = 1'b0;
      idle();
      test_reset();
      test_single();
      test_wrap();
      test_back_to_back();
      test_stall();
      test_bubble();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/ex_mul_pipeline.md
Name: ex_mul_pipeline

Overview:
- Five-stage execute pipeline for the multi-cycle MUL path. Sits beside the single-cycle ALU, between decode and writeback.
- Per stage it tracks valid, destination register and data, and exports the ex1..ex5 valid/destination view that decode-side hazard detection consumes.
- Honours the stall and bubble controls issued by the hazard logic.
- Produces the writeback request for ex5 and an early "writeback next cycle" indication.

Parameters:
- DATA_WIDTH, 32, operand/result width; must be even (split into halves in ex2).
- REGISTER_WIDTH, params_pkg::REGISTER_WIDTH (5), architectural register index width.

Ports:
- clk_i  in  1  clock
- rsn_i  in  1  synchronous active-low reset
- issue_valid_i  in  1  decode presents a MUL instruction for ex1
- issue_rd_i  in  REGISTER_WIDTH  destination register of issuing instruction
- issue_rs1_data_i  in  DATA_WIDTH  operand A
- issue_rs2_data_i  in  DATA_WIDTH  operand B
- stall_i  in  1  freeze entire pipeline (writeback not granted)
- bubble_i  in  1  load a bubble into ex1 instead of the issue
- ex1_valid_o..ex5_valid_o  out  1 each  stage holds a live instruction
- ex1_wr_reg_o..ex5_wr_reg_o  out  REGISTER_WIDTH each  stage destination register
- wb_is_next_cycle_o  out  1  ex4 live; result reaches ex5 next unstalled cycle
- wb_valid_o  out  1  ex5 result is written back this cycle
- wb_rd_o  out  REGISTER_WIDTH  writeback register (= ex5_wr_reg_o)
- wb_data_o  out  DATA_WIDTH  low DATA_WIDTH bits of A*B
- busy_o  out  1  OR of ex1..ex5 valid

Behaviour:
- Reset (rsn_i low at posedge): all stage valids 0, all wr_reg and data registers 0. Therefore every output is 0 after reset.
- Reset mid-operation discards all in-flight instructions; no writeback is produced for them.
- Advance rule, evaluated at each posedge with rsn_i high:
  - If stall_i=1, every stage register (valid, rd, data) holds.
  - Otherwise each stage k+1 takes stage k, and ex5 contents retire.
- ex1 load when not stalled:
  - issue_valid_i=1 and bubble_i=0: valid=1, rd=issue_rd_i, operands captured.
  - Otherwise: valid=0, and rd/data are held at their old values (don't-care).
- stall_i and bubble_i both high: stall wins, ex1 holds.
- Datapath (all lower-case halves are DATA_WIDTH/2 bits):
  - ex1 registers A and B.
  - ex2 registers partial products al*bl, al*bh, ah*bl (each DATA_WIDTH wide). ah*bh is not computed: it cannot affect the low half.
  - ex3 registers sum = al*bl + ((al*bh + ah*bl) << DATA_WIDTH/2), truncated to DATA_WIDTH with wrap-around. Signedness is irrelevant for the low half.
  - ex4 and ex5 carry the result unchanged.
- Latency: an instruction issued at cycle N (ex1 valid from N+1) has wb_valid_o high in cycle N+5 with no stalls. Each stall cycle adds one cycle.
- wb_valid_o = ex5_valid & ~stall_i (combinational). wb_rd_o and wb_data_o always reflect ex5.
- wb_is_next_cycle_o = ex4_valid (combinational).
- Back-to-back issue is supported: one instruction per unstalled cycle, five in flight maximum.
- rd=0 instructions flow normally. The register file discards x0 writes; this block does not filter them.
- The ex*_valid_o / ex*_wr_reg_o outputs are registered stage contents and combinationally independent of inputs, so there is no loop with the hazard logic.

Decomposition:
- params_pkg gains:
  - ex_stage_t struct {valid, rd, data}
  - localparam EX_STAGES = 5
- The pipeline is an array of ex_stage_t (plus operand/partial-product fields).
- One sub-module: mul_lo_partial, a purely combinational helper producing the three partial products from A and B. It is instantiated in ex2 and unit-testable alone.

Test Plan:
- Single issue: A=7, B=6, rd=3, no stall -> ex1..ex5 valid on successive cycles with wr_reg=3; wb_is_next_cycle_o high in cycle 4; wb_valid_o, wb_rd_o=3, wb_data_o=42 in cycle 5.
- Wrap and mixed sign: A=0xFFFFFFFF, B=0xFFFFFFFF -> wb_data_o=0x00000001. A=0x80000000, B=2 -> 0x00000000. A=0x00012345, B=0x00010000 -> 0x23450000.
- Back-to-back: five issues rd=1..5 on consecutive cycles -> all ex1..ex5 valid with wr_reg 5,4,3,2,1; busy_o=1; five consecutive writebacks in order with correct products.
- Stall: stall_i high 3 cycles while ex5 holds rd=9 -> wb_valid_o=0 and all stage registers unchanged during the stall; writeback occurs the first cycle stall_i drops; total latency 8.
- Bubble and conflict: issue_valid_i=1 with bubble_i=1 -> ex1_valid_o=0 next cycle. stall_i=1 and bubble_i=1 with ex1 holding rd=4 -> ex1 still valid, rd=4.
- Reset mid-flight: three instructions in flight, rsn_i low one cycle -> all valids 0, wb_valid_o never asserts for them; a new issue afterwards completes in 5 cycles.
